// File: rtl/irq_pending_latch.sv
// irq_pending_latch
// Request front end for the priority encoder. Each raw request line is
// synchronised, its rising edge detected, and the event is held in pend_raw
// until the consumer acknowledges that index. A mask hides lines from the
// encoder without discarding their events. Sticky overrun flags record
// events that arrive while the line is still pending.

module irq_pending_latch #(
    parameter int N = 3,
    parameter int M = 1 << N
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic [M-1:0] req,
    input  logic         mask_we,
    input  logic [M-1:0] mask_wdata,
    input  logic         ack,
    input  logic [N-1:0] ack_idx,
    input  logic         ovf_clr,
    output logic [M-1:0] pend,
    output logic         pend_any,
    output logic [M-1:0] mask,
    output logic [M-1:0] ovf
);

    logic [M-1:0] s1_reg;
    logic [M-1:0] s2_reg;
    logic [M-1:0] s3_reg;
    logic [M-1:0] pend_raw_reg;
    logic [M-1:0] mask_reg;
    logic [M-1:0] ovf_reg;

    logic [M-1:0] rise;
    logic [M-1:0] ack_vec;
    logic [M-1:0] pend_raw_next;
    logic [M-1:0] ovf_next;

    // One-hot decode of the acknowledged index; M is always 2^N so every
    // ack_idx value selects a real line.
    always_comb begin
        ack_vec = '0;
        if (ack) begin
            ack_vec[ack_idx] = 1'b1;
        end
    end

    // Per-line event logic: a new rise always wins over an ack of the same
    // bit, and an overrun only counts when the held event is not being
    // serviced on that edge. A fresh overrun also wins over ovf_clr.
    for (genvar gi = 0; gi < M; gi++) begin : g_line
        assign rise[gi]          = s2_reg[gi] & ~s3_reg[gi];
        assign pend_raw_next[gi] = rise[gi] | (pend_raw_reg[gi] & ~ack_vec[gi]);
        assign ovf_next[gi]      = (rise[gi] & pend_raw_reg[gi] & ~ack_vec[gi])
                                 | (ovf_reg[gi] & ~ovf_clr);
    end

    // State update: sync chain, edge history, pending, mask and overrun.
    // s3 clears on reset so a line held high across reset yields one event.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            s1_reg       <= '0;
            s2_reg       <= '0;
            s3_reg       <= '0;
            pend_raw_reg <= '0;
            mask_reg     <= '0;
            ovf_reg      <= '0;
        end else begin
            s1_reg       <= req;
            s2_reg       <= s1_reg;
            s3_reg       <= s2_reg;
            pend_raw_reg <= pend_raw_next;
            ovf_reg      <= ovf_next;
            if (mask_we) begin
                mask_reg <= mask_wdata;
            end
        end
    end

    // Outputs depend on registers only; no path from req or ack.
    assign pend     = pend_raw_reg & ~mask_reg;
    assign pend_any = |pend;
    assign mask     = mask_reg;
    assign ovf      = ovf_reg;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Testbench for irq_pending_latch (N=3, M=8). A table of per-edge vectors is
// applied in order; the expected outputs of each vector are pushed into a
// scoreboard queue as it is driven and popped one edge later for comparison.
// Reset behaviour is exercised by hand-written sequences around the table.

module tb_irq_pending_latch;

    localparam int N = 3;
    localparam int M = 8;

    logic         clk;
    logic         clr_n;
    logic [M-1:0] req;
    logic         mask_we;
    logic [M-1:0] mask_wdata;
    logic         ack;
    logic [N-1:0] ack_idx;
    logic         ovf_clr;
    logic [M-1:0] pend;
    logic         pend_any;
    logic [M-1:0] mask;
    logic [M-1:0] ovf;

    irq_pending_latch #(.N(N), .M(M)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .req        (req),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ack        (ack),
        .ack_idx    (ack_idx),
        .ovf_clr    (ovf_clr),
        .pend       (pend),
        .pend_any   (pend_any),
        .mask       (mask),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       mwe;
        logic [7:0] mwd;
        logic       ack;
        logic [2:0] aidx;
        logic       oclr;
        logic [7:0] epend;
        logic [7:0] emask;
        logic [7:0] eovf;
    } vec_t;

    typedef struct {
        int         idx;
        logic [7:0] pend;
        logic       any;
        logic [7:0] mask;
        logic [7:0] ovf;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   split_idx;

    task automatic add(input logic [7:0] r, input logic mwe, input logic [7:0] mwd,
                       input logic a, input logic [2:0] ai, input logic oc,
                       input logic [7:0] ep, input logic [7:0] em, input logic [7:0] eo);
        vec_t v;
        v.req = r; v.mwe = mwe; v.mwd = mwd; v.ack = a; v.aidx = ai; v.oclr = oc;
        v.epend = ep; v.emask = em; v.eovf = eo;
        vecs.push_back(v);
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    task automatic check_zero(input string tag);
        chk8({tag, " pend"}, pend, 8'h00);
        chk1({tag, " pend_any"}, pend_any, 1'b0);
        chk8({tag, " mask"}, mask, 8'h00);
        chk8({tag, " ovf"}, ovf, 8'h00);
        $display("%s: pend=%h any=%b mask=%h ovf=%h", tag, pend, pend_any, mask, ovf);
    endtask

    // Drive one vector (called away from the clock edge), record its
    // expectation, then compare after the edge.
    task automatic run_vec(input int i);
        exp_t e;
        exp_t got;
        req        = vecs[i].req;
        mask_we    = vecs[i].mwe;
        mask_wdata = vecs[i].mwd;
        ack        = vecs[i].ack;
        ack_idx    = vecs[i].aidx;
        ovf_clr    = vecs[i].oclr;
        e.idx  = i;
        e.pend = vecs[i].epend;
        e.any  = |vecs[i].epend;
        e.mask = vecs[i].emask;
        e.ovf  = vecs[i].eovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk8($sformatf("v%0d pend", got.idx), pend, got.pend);
        chk1($sformatf("v%0d pend_any", got.idx), pend_any, got.any);
        chk8($sformatf("v%0d mask", got.idx), mask, got.mask);
        chk8($sformatf("v%0d ovf", got.idx), ovf, got.ovf);
        $display("v%0d: req=%h ack=%b/%0d mwe=%b oclr=%b -> pend=%h any=%b mask=%h ovf=%h",
                 got.idx, vecs[i].req, vecs[i].ack, vecs[i].aidx, vecs[i].mwe,
                 vecs[i].oclr, pend, pend_any, mask, ovf);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Columns: req, mask_we, mask_wdata, ack, ack_idx, ovf_clr, pend, mask, ovf
        // Release with all requests high: event appears after the 3rd edge only.
        add(8'hFF,0,8'h00,0,0,0, 8'h00,8'h00,8'h00);
        add(8'hFF,0,8'h00,0,0,0, 8'h00,8'h00,8'h00);
        add(8'hFF,0,8'h00,0,0,0, 8'hFF,8'h00,8'h00);
        add(8'hFF,0,8'h00,0,0,0, 8'hFF,8'h00,8'h00);
        // Drop requests and acknowledge every index in turn.
        add(8'h00,0,8'h00,1,0,0, 8'hFE,8'h00,8'h00);
        add(8'h00,0,8'h00,1,1,0, 8'hFC,8'h00,8'h00);
        add(8'h00,0,8'h00,1,2,0, 8'hF8,8'h00,8'h00);
        add(8'h00,0,8'h00,1,3,0, 8'hF0,8'h00,8'h00);
        add(8'h00,0,8'h00,1,4,0, 8'hE0,8'h00,8'h00);
        add(8'h00,0,8'h00,1,5,0, 8'hC0,8'h00,8'h00);
        add(8'h00,0,8'h00,1,6,0, 8'h80,8'h00,8'h00);
        add(8'h00,0,8'h00,1,7,0, 8'h00,8'h00,8'h00);
        // Single event on line 5, held after req drops, then acked.
        add(8'h20,0,8'h00,0,0,0, 8'h00,8'h00,8'h00);
        add(8'h20,0,8'h00,0,0,0, 8'h00,8'h00,8'h00);
        add(8'h20,0,8'h00,0,0,0, 8'h20,8'h00,8'h00);
        add(8'h00,0,8'h00,0,0,0, 8'h20,8'h00,8'h00);
        add(8'h00,0,8'h00,0,0,0, 8'h20,8'h00,8'h00);
        add(8'h00,0,8'h00,1,5,0, 8'h00,8'h00,8'h00);
        // Set/ack collision on line 5: set wins, no overrun.
        add(8'h20,0,8'h00,0,0,0, 8'h00,8'h00,8'h00);
        add(8'h20,0,8'h00,0,0,0, 8'h00,8'h00,8'h00);
        add(8'h20,0,8'h00,0,0,0, 8'h20,8'h00,8'h00);
        add(8'h00,0,8'h00,0,0,0, 8'h20,8'h00,8'h00);
        add(8'h00,0,8'h00,0,0,0, 8'h20,8'h00,8'h00);
        add(8'h00,0,8'h00,0,0,0, 8'h20,8'h00,8'h00);
        add(8'h20,0,8'h00,0,0,0, 8'h20,8'h00,8'h00);
        add(8'h20,0,8'h00,0,0,0, 8'h20,8'h00,8'h00);
        add(8'h20,0,8'h00,1,5,0, 8'h20,8'h00,8'h00);
        add(8'h00,0,8'h00,1,5,0, 8'h00,8'h00,8'h00);
        add(8'h00,0,8'h00,0,0,0, 8'h00,8'h00,8'h00);
        add(8'h00,0,8'h00,0,0,0, 8'h00,8'h00,8'h00);
        // Overrun on line 2: two pulses, no ack; then ovf_clr.
        add(8'h04,0,8'h00,0,0,0, 8'h00,8'h00,8'h00);
        add(8'h04,0,8'h00,0,0,0, 8'h00,8'h00,8'h00);
        add(8'h04,0,8'h00,0,0,0, 8'h04,8'h00,8'h00);
        add(8'h00,0,8'h00,0,0,0, 8'h04,8'h00,8'h00);
        add(8'h00,0,8'h00,0,0,0, 8'h04,8'h00,8'h00);
        add(8'h00,0,8'h00,0,0,0, 8'h04,8'h00,8'h00);
        add(8'h04,0,8'h00,0,0,0, 8'h04,8'h00,8'h00);
        add(8'h04,0,8'h00,0,0,0, 8'h04,8'h00,8'h00);
        add(8'h04,0,8'h00,0,0,0, 8'h04,8'h00,8'h04);
        add(8'h00,0,8'h00,0,0,1, 8'h04,8'h00,8'h00);
        add(8'h00,0,8'h00,0,0,0, 8'h04,8'h00,8'h00);
        add(8'h00,0,8'h00,0,0,0, 8'h04,8'h00,8'h00);
        // Mask line 7 (and ack line 2), event on 7 is held but hidden.
        add(8'h00,1,8'h80,1,2,0, 8'h00,8'h80,8'h00);
        add(8'h80,0,8'h00,0,0,0, 8'h00,8'h80,8'h00);
        add(8'h80,0,8'h00,0,0,0, 8'h00,8'h80,8'h00);
        add(8'h80,0,8'h00,0,0,0, 8'h00,8'h80,8'h00);
        add(8'h00,1,8'h00,0,0,0, 8'h80,8'h00,8'h00);
        add(8'h00,0,8'h00,1,7,0, 8'h00,8'h00,8'h00);
        add(8'h00,0,8'h00,0,0,0, 8'h00,8'h00,8'h00);
        // Build pend=24, ovf=04, mask=01 ahead of the mid-run reset.
        add(8'h24,0,8'h00,0,0,0, 8'h00,8'h00,8'h00);
        add(8'h24,0,8'h00,0,0,0, 8'h00,8'h00,8'h00);
        add(8'h24,0,8'h00,0,0,0, 8'h24,8'h00,8'h00);
        add(8'h00,0,8'h00,0,0,0, 8'h24,8'h00,8'h00);
        add(8'h00,0,8'h00,0,0,0, 8'h24,8'h00,8'h00);
        add(8'h00,0,8'h00,0,0,0, 8'h24,8'h00,8'h00);
        add(8'h04,0,8'h00,0,0,0, 8'h24,8'h00,8'h00);
        add(8'h04,0,8'h00,0,0,0, 8'h24,8'h00,8'h00);
        add(8'h04,1,8'h01,0,0,0, 8'h24,8'h01,8'h04);
        split_idx = vecs.size();
        // After reset release with req[2] still high: exactly one event.
        add(8'h04,0,8'h00,0,0,0, 8'h00,8'h00,8'h00);
        add(8'h04,0,8'h00,0,0,0, 8'h00,8'h00,8'h00);
        add(8'h04,0,8'h00,0,0,0, 8'h04,8'h00,8'h00);
        add(8'h04,0,8'h00,0,0,0, 8'h04,8'h00,8'h00);
        // Overrun on the same edge as ovf_clr: overrun wins.
        add(8'h00,0,8'h00,0,0,0, 8'h04,8'h00,8'h00);
        add(8'h00,0,8'h00,0,0,0, 8'h04,8'h00,8'h00);
        add(8'h00,0,8'h00,0,0,0, 8'h04,8'h00,8'h00);
        add(8'h04,0,8'h00,0,0,0, 8'h04,8'h00,8'h00);
        add(8'h04,0,8'h00,0,0,0, 8'h04,8'h00,8'h00);
        add(8'h04,0,8'h00,0,0,1, 8'h04,8'h00,8'h04);
        // Ack of a masked pending bit still clears it.
        add(8'h04,1,8'h04,0,0,0, 8'h00,8'h04,8'h04);
        add(8'h04,0,8'h00,1,2,0, 8'h00,8'h04,8'h04);
        add(8'h04,1,8'h00,0,0,0, 8'h00,8'h00,8'h04);

        // Initial reset with all requests high.
        clr_n      = 1'b0;
        req        = 8'hFF;
        mask_we    = 1'b0;
        mask_wdata = 8'h00;
        ack        = 1'b0;
        ack_idx    = 3'd0;
        ovf_clr    = 1'b0;
        #2;
        check_zero("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_held");
        @(negedge clk);
        clr_n = 1'b1;

        for (int i = 0; i < split_idx; i++) begin
            run_vec(i);
        end

        // Asynchronous reset between edges: state clears without a clock.
        #2;
        clr_n = 1'b0;
        #1;
        check_zero("reset_midrun");
        #2;
        clr_n = 1'b1;

        for (int i = split_idx; i < vecs.size(); i++) begin
            run_vec(i);
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
